// File: rtl/serial_tx_packer.sv
// Parallel-to-serial packer: takes words over valid/ready and shifts them out one bit per clock,
// using a one-word hold register so back-to-back words stream without idle cycles.
module serial_tx_packer #(
   parameter int WIDTH     = 8,
   parameter int GAP       = 0,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] parIn,
   input  logic             parValid,
   output logic             parReady,
   output logic             dataOut,
   output logic             dataOutValid,
   output logic             busy
);

   localparam int BW = $clog2(WIDTH);
   localparam int GW = 4;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t           state_r, state_n;
   logic [WIDTH-1:0] shift_r, shift_n;
   logic [BW-1:0]    bit_cnt_r, bit_cnt_n;
   logic [GW-1:0]    gap_cnt_r, gap_cnt_n;
   logic [WIDTH-1:0] hold_r, hold_n;
   logic             hold_full_r, hold_full_n;
   logic             ready_r;
   logic             dout_r, dout_n;
   logic             dvalid_r, dvalid_n;
   logic             busy_r;
   logic             accept_s;
   logic             free_s;
   logic [WIDTH-1:0] load_word_s;

   // Bit that goes on the wire first for a given word.
   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) begin
         return w[WIDTH-1];
      end else begin
         return w[0];
      end
   endfunction

   // Word with its already-transmitted bit shifted away.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) begin
         return {w[WIDTH-2:0], 1'b0};
      end else begin
         return {1'b0, w[WIDTH-1:1]};
      end
   endfunction

   // Next-state, load selection and next output values.
   always_comb begin
      state_n     = state_r;
      shift_n     = shift_r;
      bit_cnt_n   = bit_cnt_r;
      gap_cnt_n   = gap_cnt_r;
      hold_n      = hold_r;
      hold_full_n = hold_full_r;
      dout_n      = 1'b0;
      dvalid_n    = 1'b0;
      free_s      = 1'b0;
      load_word_s = parIn;
      accept_s    = parValid && ready_r;

      case (state_r)
         ST_IDLE: begin
            free_s = 1'b1;
         end
         ST_SHIFT: begin
            if (bit_cnt_r == BIT_LAST) begin
               if (GAP == 0) begin
                  free_s = 1'b1;
               end else begin
                  state_n   = ST_GAP;
                  gap_cnt_n = '0;
               end
            end else begin
               dout_n    = first_bit(shift_r);
               dvalid_n  = 1'b1;
               shift_n   = advance(shift_r);
               bit_cnt_n = bit_cnt_r + 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_cnt_r == GAP_LAST) begin
               free_s = 1'b1;
            end else begin
               gap_cnt_n = gap_cnt_r + 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      // A held word always wins over a fresh one; ready is low while hold is full.
      if (free_s) begin
         if (hold_full_r) begin
            load_word_s = hold_r;
            hold_full_n = 1'b0;
         end else begin
            load_word_s = parIn;
         end
         if (hold_full_r || accept_s) begin
            state_n   = ST_SHIFT;
            dout_n    = first_bit(load_word_s);
            dvalid_n  = 1'b1;
            shift_n   = advance(load_word_s);
            bit_cnt_n = '0;
            gap_cnt_n = '0;
         end else begin
            state_n = ST_IDLE;
         end
      end else if (accept_s) begin
         hold_n      = parIn;
         hold_full_n = 1'b1;
      end else begin
         hold_n = hold_r;
      end
   end

   // State, datapath and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         shift_r     <= '0;
         bit_cnt_r   <= '0;
         gap_cnt_r   <= '0;
         hold_r      <= '0;
         hold_full_r <= 1'b0;
         ready_r     <= 1'b1;
         dout_r      <= 1'b0;
         dvalid_r    <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_n;
         shift_r     <= shift_n;
         bit_cnt_r   <= bit_cnt_n;
         gap_cnt_r   <= gap_cnt_n;
         hold_r      <= hold_n;
         hold_full_r <= hold_full_n;
         ready_r     <= !hold_full_n;
         dout_r      <= dout_n;
         dvalid_r    <= dvalid_n;
         busy_r      <= (state_n != ST_IDLE) || hold_full_n;
      end
   end

   assign parReady     = ready_r;
   assign dataOut      = dout_r;
   assign dataOutValid = dvalid_r;
   assign busy         = busy_r;

endmodule

// File: tb/tb_serial_tx_packer.sv
// Bench for serial_tx_packer: three instances (GAP=0 MSB-first, GAP=2 MSB-first, GAP=0 LSB-first)
// with a bit-level scoreboard fed at each accepting edge.
module tb_serial_tx_packer;

   typedef struct {
      int         d;
      logic [7:0] w;
      logic [7:0] e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] par_in    [3];
   logic       par_valid [3];
   logic       par_ready [3];
   logic       dout      [3];
   logic       dvalid    [3];
   logic       busy      [3];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit q0[$];
   bit q1[$];
   bit q2[$];
   int   run_len[3];
   int   max_run[3];
   int   last_start[3];
   int   prev_start[3];
   logic prev_v[3];
   bit   mon_en = 1'b0;

   serial_tx_packer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) u_dut0 (
      .clk(clk), .rst(rst), .parIn(par_in[0]), .parValid(par_valid[0]), .parReady(par_ready[0]),
      .dataOut(dout[0]), .dataOutValid(dvalid[0]), .busy(busy[0]));

   serial_tx_packer #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .parIn(par_in[1]), .parValid(par_valid[1]), .parReady(par_ready[1]),
      .dataOut(dout[1]), .dataOutValid(dvalid[1]), .busy(busy[1]));

   serial_tx_packer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0)) u_dut2 (
      .clk(clk), .rst(rst), .parIn(par_in[2]), .parValid(par_valid[2]), .parReady(par_ready[2]),
      .dataOut(dout[2]), .dataOutValid(dvalid[2]), .busy(busy[2]));

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int qsize(input int d);
      case (d)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic qpush(input int d, input bit b);
      case (d)
         0: q0.push_back(b);
         1: q1.push_back(b);
         default: q2.push_back(b);
      endcase
   endtask

   task automatic qpop(input int d, output bit b);
      case (d)
         0: b = q0.pop_front();
         1: b = q1.pop_front();
         default: b = q2.pop_front();
      endcase
   endtask

   task automatic qclear(input int d);
      case (d)
         0: q0.delete();
         1: q1.delete();
         default: q2.delete();
      endcase
   endtask

   // Present a word, wait (bounded) for ready, push its expected bit order, pass the accepting edge.
   task automatic send(input int d, input logic [7:0] w, input logic [7:0] e, output int waits);
      waits = 0;
      par_in[d]    = w;
      par_valid[d] = 1'b1;
      while (par_ready[d] !== 1'b1 && waits < 200) begin
         @(posedge clk);
         #1;
         waits++;
      end
      if (par_ready[d] !== 1'b1) begin
         check("accept_timeout", par_ready[d], 1'b1);
      end else begin
         for (int k = 7; k >= 0; k--) qpush(d, e[k]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int d);
      int n = 0;
      while (busy[d] !== 1'b0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_reached", busy[d], 1'b0);
   endtask

   // Scoreboard monitor: every valid bit must match the head of its queue; idle cycles carry 0.
   initial begin
      bit b;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
               if (dvalid[d] === 1'b1) begin
                  if (qsize(d) == 0) begin
                     check($sformatf("unexpected_bit_d%0d", d), dvalid[d], 1'b0);
                  end else begin
                     qpop(d, b);
                     check($sformatf("bit_d%0d", d), dout[d], b);
                  end
                  if (prev_v[d] !== 1'b1) begin
                     prev_start[d] = last_start[d];
                     last_start[d] = cyc;
                  end
                  run_len[d]++;
                  if (run_len[d] > max_run[d]) max_run[d] = run_len[d];
               end else begin
                  check($sformatf("idle_dout_d%0d", d), dout[d], 1'b0);
                  run_len[d] = 0;
               end
               prev_v[d] = dvalid[d];
            end
         end
      end
   end

   initial begin
      vec_t       tbl[6];
      int         waits;
      int         d;
      logic [7:0] e;

      tbl[0] = '{0, 8'hB4, 8'hB4};
      tbl[1] = '{0, 8'h3C, 8'h3C};
      tbl[2] = '{1, 8'h81, 8'h81};
      tbl[3] = '{2, 8'h01, 8'h80};
      tbl[4] = '{2, 8'hB4, 8'h2D};
      tbl[5] = '{2, 8'h96, 8'h69};

      for (int i = 0; i < 3; i++) begin
         par_in[i]    = 8'h00;
         par_valid[i] = 1'b0;
         run_len[i]   = 0;
         max_run[i]   = 0;
         last_start[i] = 0;
         prev_start[i] = 0;
      end

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("reset_ready", par_ready[i], 1'b1);
         check("reset_dout", dout[i], 1'b0);
         check("reset_valid", dvalid[i], 1'b0);
         check("reset_busy", busy[i], 1'b0);
      end

      // Single words: latency, exact length, and state right after the last bit.
      for (int i = 0; i < 6; i++) begin
         d = tbl[i].d;
         e = tbl[i].e;
         send(d, tbl[i].w, e, waits);
         par_valid[d] = 1'b0;
         check("first_valid", dvalid[d], 1'b1);
         check("first_bit", dout[d], e[7]);
         repeat (7) @(posedge clk);
         #1;
         check("last_valid", dvalid[d], 1'b1);
         check("last_bit", dout[d], e[0]);
         @(posedge clk);
         #1;
         check("after_valid", dvalid[d], 1'b0);
         check("after_dout", dout[d], 1'b0);
         check("after_busy", busy[d], (d == 1) ? 1'b1 : 1'b0);
         wait_idle(d);
      end

      // Back-to-back FF, 00, A5 with valid held high.
      max_run[0] = 0;
      send(0, 8'hFF, 8'hFF, waits);
      send(0, 8'h00, 8'h00, waits);
      check("ready_low_after_park", par_ready[0], 1'b0);
      send(0, 8'hA5, 8'hA5, waits);
      check("ready_low_cycles", waits, 7);
      par_valid[0] = 1'b0;
      wait_idle(0);
      check("contiguous_bits", max_run[0], 24);

      // GAP=2: two words, 8-bit runs, 10-cycle period.
      max_run[1] = 0;
      send(1, 8'h81, 8'h81, waits);
      send(1, 8'h7E, 8'h7E, waits);
      par_valid[1] = 1'b0;
      wait_idle(1);
      check("gap_run_len", max_run[1], 8);
      check("gap_period", last_start[1] - prev_start[1], 10);

      // Reset after the 3rd bit of FF with 3C parked in hold.
      send(0, 8'hFF, 8'hFF, waits);
      send(0, 8'h3C, 8'h3C, waits);
      @(posedge clk);
      #1;
      par_valid[0] = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      qclear(0);
      check("rst_mid_valid", dvalid[0], 1'b0);
      check("rst_mid_ready", par_ready[0], 1'b1);
      check("rst_mid_busy", busy[0], 1'b0);
      repeat (20) @(posedge clk);
      #1;
      send(0, 8'hC3, 8'hC3, waits);
      par_valid[0] = 1'b0;
      wait_idle(0);

      // Valid pulsed while ready is low, then dropped: that word must never appear.
      send(0, 8'h5A, 8'h5A, waits);
      send(0, 8'h96, 8'h96, waits);
      par_in[0]    = 8'h11;
      par_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      check("abort_ready_low", par_ready[0], 1'b0);
      @(posedge clk);
      #1;
      par_valid[0] = 1'b0;
      wait_idle(0);

      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) check($sformatf("queue_drained_d%0d", i), qsize(i), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_tx_packer.md
# serial_tx_packer

Upstream feeder for the serial processing stage. Accepts parallel words over a valid/ready handshake and emits each one as a serial bit stream on `dataOut`, one bit per clock, with a qualifying `dataOutValid` strobe. A one-word holding register lets the next word be accepted while the current one shifts, so back-to-back words leave no idle cycles. Its `dataOut` drives the `dataIn` input of the downstream serial stage directly.

## Interface
- `WIDTH`, 8: bits per parallel word; legal range 2..32.
- `GAP`, 0: idle cycles inserted after each word's last bit; legal range 0..15.
- `MSB_FIRST`, 1: 1 = bit `WIDTH-1` is sent first; 0 = bit 0 is sent first.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high. One clock, all state on its rising edge.
- `parIn`  in  WIDTH  parallel word; sampled only on an accepting edge.
- `parValid`  in  1  `parIn` holds a valid word.
- `parReady`  out  1  block can accept a word this cycle.
- `dataOut`  out  1  serial bit, registered.
- `dataOutValid`  out  1  `dataOut` carries a payload bit this cycle, registered.
- `busy`  out  1  shifter active (SHIFT or GAP) or holding register full.

## Operation
- Storage:
  - `hold` register: WIDTH bits plus `holdFull` flag.
  - Shift register: WIDTH bits.
  - Bit counter: 0..WIDTH-1.
  - Gap counter: 0..GAP-1.
- FSM states: IDLE, SHIFT, GAP. When `GAP` = 0, GAP is never entered.
- `parReady = !holdFull`. It is driven directly from a flop, with no combinational path from `parValid`.
- Accept occurs on an edge where `parValid && parReady`.
- The shifter is "free at edge E" in any of these cases:
  - it is in IDLE;
  - it is in SHIFT on the last bit with `GAP` = 0;
  - it is in GAP on the last gap cycle.
- Load priority at a free edge:
  1. If `holdFull`, load `hold` into the shifter and clear `holdFull`.
  2. Otherwise, if an accept occurs, load `parIn` into the shifter directly.
  3. Otherwise, go to IDLE.
- Accept while the shifter is busy, or while the hold is being drained: the word goes into `hold` and `holdFull` is set. This can only occur while `holdFull` = 0.
- Simultaneous hold drain and accept on the same edge is impossible, because `parReady` is 0 whenever `hold` is full.
- SHIFT:
  - Each edge presents the next bit on `dataOut` with `dataOutValid` = 1.
  - After WIDTH bits, go to GAP if `GAP` > 0, otherwise apply the load rule.
- GAP: `dataOut` = 0 and `dataOutValid` = 0 for exactly `GAP` cycles, then apply the load rule.
- IDLE: `dataOut` = 0, `dataOutValid` = 0.
- Reset (`rst` = 1 at an edge), including mid-word:
  - state goes to IDLE; `holdFull`, both counters and the shift register clear;
  - the partial word and any held word are discarded;
  - outputs take reset values at that edge;
  - `parIn` is ignored while `rst` = 1.
- `parValid` deasserting without an accept is legal. The block does not require `parIn` to stay stable.

## Timing
- Reset values: `parReady` = 1, `dataOut` = 0, `dataOutValid` = 0, `busy` = 0.
- Latency: a word accepted at edge N into a free shifter puts its first bit on `dataOut` right after edge N. The last bit follows edge N+WIDTH-1.
- Back-to-back with `GAP` = 0: `dataOutValid` stays continuously high across words.
- Word period is WIDTH+GAP cycles.
- `parReady` falls the cycle after a word is parked in `hold`. It rises the cycle after `hold` drains into the shifter.
- `busy` falls the cycle after the last bit (or the last gap cycle) when no word is pending.

## Test plan
- Single word, `WIDTH`=8, `GAP`=0, `MSB_FIRST`=1, `parIn`=8'hB4 accepted at edge N:
  - `dataOut` = 1,0,1,1,0,1,0,0 after edges N..N+7 with `dataOutValid` high;
  - then `dataOutValid`=0, `dataOut`=0, `busy`=0.
- Back-to-back, `parValid` held high with 8'hFF, 8'h00, 8'hA5:
  - 24 contiguous valid bits, FF then 00 then A5;
  - `parReady` low from the cycle after the 2nd accept until the first hold drain, with no bubble in `dataOutValid`.
- `GAP`=2, words 8'h81 and 8'h7E back-to-back:
  - 8 valid bits, then exactly 2 cycles of `dataOutValid`=0 and `dataOut`=0, then 8 valid bits;
  - word period is 10 cycles.
- `MSB_FIRST`=0, `parIn`=8'h01: first bit 1, then seven 0s.
- Reset mid-word: `rst`=1 for one edge after the 3rd bit of 8'hFF, with another word held in `hold`:
  - next cycle `dataOutValid`=0, `parReady`=1, `busy`=0;
  - no further bits of either word appear;
  - a fresh 8'hC3 then shifts out correctly.
- Handshake abort: `parValid` pulsed while `parReady`=0, then dropped:
  - that word is never transmitted;
  - the currently shifting word completes unchanged.
